// File: rtl/cp0_unit.sv
// Coprocessor-0 for the P7 pipelined MIPS core: SR/Cause/EPC/PRId, interrupt and exception arbitration.
// Optional Count/Compare timer enabled by defining CP0_TIMER_EN.
module cp0_unit #(
  parameter logic [31:0] EXC_ENTRY = 32'h0000_4180,
  parameter logic [31:0] PRID_VAL  = 32'h2021_0707
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [4:0]  cp0_addr,
  input  logic [31:0] cp0_wdata,
  output logic [31:0] cp0_rdata,
  input  logic [31:0] vpc,
  input  logic        bd_in,
  input  logic [4:0]  exc_code_in,
  input  logic [5:0]  hw_int,
  input  logic        eret,
  output logic        req,
  output logic [31:0] handler_pc,
  output logic [31:0] epc_out
);

  localparam logic [4:0] ADDR_COUNT   = 5'd9;
  localparam logic [4:0] ADDR_COMPARE = 5'd11;
  localparam logic [4:0] ADDR_SR      = 5'd12;
  localparam logic [4:0] ADDR_CAUSE   = 5'd13;
  localparam logic [4:0] ADDR_EPC     = 5'd14;
  localparam logic [4:0] ADDR_PRID    = 5'd15;

  logic [5:0]  im_q, im_d;
  logic        exl_q, exl_d;
  logic        ie_q, ie_d;
  logic        bd_q, bd_d;
  logic [5:0]  ip_q, ip_d;
  logic [4:0]  exc_code_q, exc_code_d;
  logic [31:0] epc_q, epc_d;

  logic [5:0]  ip_eff;
  logic        int_req;
  logic        exc_req;
  logic        mtc0_ok;
  logic [31:0] epc_victim;

`ifdef CP0_TIMER_EN
  logic [31:0] count_q, count_d;
  logic [31:0] compare_q, compare_d;
  logic        timer_pend_q, timer_pend_d;

  // Timer pending ORs into IP[7], which is the top bit of the IP field.
  assign ip_eff = {ip_q[5] | timer_pend_q, ip_q[4:0]};
`else
  assign ip_eff = ip_q;
`endif

  assign int_req    = (|(ip_eff & im_q)) & ie_q & ~exl_q;
  assign exc_req    = (exc_code_in != 5'd0) & ~exl_q;
  assign req        = int_req | exc_req;
  assign mtc0_ok    = we & ~req;
  assign handler_pc = EXC_ENTRY;
  assign epc_victim = (bd_in ? (vpc - 32'd4) : vpc) & ~32'h3;
  assign epc_out    = (mtc0_ok && cp0_addr == ADDR_EPC) ? cp0_wdata : epc_q;

  always_comb begin
    im_d       = im_q;
    exl_d      = exl_q;
    ie_d       = ie_q;
    bd_d       = bd_q;
    ip_d       = hw_int;
    exc_code_d = exc_code_q;
    epc_d      = epc_q;
    if (req) begin
      exl_d      = 1'b1;
      bd_d       = bd_in;
      exc_code_d = int_req ? 5'd0 : exc_code_in;
      epc_d      = epc_victim;
    end else begin
      // eret owns EXL this cycle, so an mtc0 to SR is discarded wholesale.
      if (mtc0_ok && cp0_addr == ADDR_SR && !eret) begin
        im_d  = cp0_wdata[15:10];
        exl_d = cp0_wdata[1];
        ie_d  = cp0_wdata[0];
      end
      if (eret) exl_d = 1'b0;
      if (mtc0_ok && cp0_addr == ADDR_EPC) epc_d = cp0_wdata;
    end
  end

`ifdef CP0_TIMER_EN
  always_comb begin
    count_d      = count_q + 32'd1;
    compare_d    = compare_q;
    timer_pend_d = timer_pend_q | ((count_q == compare_q) && (compare_q != 32'd0));
    if (mtc0_ok && cp0_addr == ADDR_COUNT) count_d = cp0_wdata;
    if (mtc0_ok && cp0_addr == ADDR_COMPARE) begin
      compare_d    = cp0_wdata;
      timer_pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q      <= 32'd0;
      compare_q    <= 32'd0;
      timer_pend_q <= 1'b0;
    end else begin
      count_q      <= count_d;
      compare_q    <= compare_d;
      timer_pend_q <= timer_pend_d;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      im_q       <= 6'd0;
      exl_q      <= 1'b0;
      ie_q       <= 1'b0;
      bd_q       <= 1'b0;
      ip_q       <= 6'd0;
      exc_code_q <= 5'd0;
      epc_q      <= 32'd0;
    end else begin
      im_q       <= im_d;
      exl_q      <= exl_d;
      ie_q       <= ie_d;
      bd_q       <= bd_d;
      ip_q       <= ip_d;
      exc_code_q <= exc_code_d;
      epc_q      <= epc_d;
    end
  end

  always_comb begin
    cp0_rdata = 32'd0;
    case (cp0_addr)
      ADDR_SR:    cp0_rdata = {16'd0, im_q, 8'd0, exl_q, ie_q};
      ADDR_CAUSE: cp0_rdata = {bd_q, 15'd0, ip_eff, 3'd0, exc_code_q, 2'd0};
      ADDR_EPC:   cp0_rdata = epc_q;
      ADDR_PRID:  cp0_rdata = PRID_VAL;
`ifdef CP0_TIMER_EN
      ADDR_COUNT:   cp0_rdata = count_q;
      ADDR_COMPARE: cp0_rdata = compare_q;
`endif
      default:    cp0_rdata = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_cp0_unit.sv
// Self-checking bench for cp0_unit: directed scenarios plus randomized traffic against a
// register-image reference model (whole 32-bit SR/Cause/EPC words with field masks).
module tb_cp0_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        we;
  logic [4:0]  cp0_addr;
  logic [31:0] cp0_wdata;
  logic [31:0] cp0_rdata;
  logic [31:0] vpc;
  logic        bd_in;
  logic [4:0]  exc_code_in;
  logic [5:0]  hw_int;
  logic        eret;
  logic        req;
  logic [31:0] handler_pc;
  logic [31:0] epc_out;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: architectural register words.
  logic [31:0] m_sr, m_cause, m_epc, m_count, m_compare;
  logic        m_pend;

  // Last observed DUT outputs, for directed literal checks.
  logic        obs_req;
  logic [31:0] obs_rdata, obs_epc_out;

  cp0_unit dut (
    .clk(clk), .reset(reset), .we(we), .cp0_addr(cp0_addr), .cp0_wdata(cp0_wdata),
    .cp0_rdata(cp0_rdata), .vpc(vpc), .bd_in(bd_in), .exc_code_in(exc_code_in),
    .hw_int(hw_int), .eret(eret), .req(req), .handler_pc(handler_pc), .epc_out(epc_out)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] m_cause_eff();
    return m_cause | (m_pend ? 32'h0000_8000 : 32'h0);
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    case (a)
      5'd12: return m_sr;
      5'd13: return m_cause_eff();
      5'd14: return m_epc;
      5'd15: return 32'h2021_0707;
`ifdef CP0_TIMER_EN
      5'd9:  return m_count;
      5'd11: return m_compare;
`endif
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic m_int_req();
    return ((m_cause_eff() & m_sr & 32'h0000_FC00) != 32'h0) && m_sr[0] && !m_sr[1];
  endfunction

  task automatic do_reset();
    reset = 1'b1; we = 1'b0; cp0_addr = 5'd0; cp0_wdata = 32'h0; vpc = 32'h0;
    bd_in = 1'b0; exc_code_in = 5'd0; hw_int = 6'd0; eret = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    m_sr = 32'h0; m_cause = 32'h0; m_epc = 32'h0;
    m_count = 32'h0; m_compare = 32'h0; m_pend = 1'b0;
  endtask

  // One clock cycle: apply inputs, check combinational outputs, advance the model.
  task automatic drive(input logic w, input logic [4:0] a, input logic [31:0] wd,
                       input logic [31:0] pc, input logic bd, input logic [4:0] exc,
                       input logic [5:0] hw, input logic er);
    logic e_int, e_req, wr_ok, nxt_pend;
    logic [31:0] e_rd, e_epc_out;
    we = w; cp0_addr = a; cp0_wdata = wd; vpc = pc; bd_in = bd;
    exc_code_in = exc; hw_int = hw; eret = er;
    @(negedge clk);
    e_int     = m_int_req();
    e_req     = e_int || (exc != 5'd0 && !m_sr[1]);
    e_rd      = m_read(a);
    e_epc_out = (w && a == 5'd14 && !e_req) ? wd : m_epc;
    obs_req = req; obs_rdata = cp0_rdata; obs_epc_out = epc_out;
    n_tests++;
    if (req !== e_req) begin
      n_fail++; $display("FAIL req: got %0b expected %0b", req, e_req);
    end
    n_tests++;
    if (cp0_rdata !== e_rd) begin
      n_fail++; $display("FAIL rdata[%0d]: got %h expected %h", a, cp0_rdata, e_rd);
    end
    n_tests++;
    if (epc_out !== e_epc_out) begin
      n_fail++; $display("FAIL epc_out: got %h expected %h", epc_out, e_epc_out);
    end
    n_tests++;
    if (handler_pc !== 32'h0000_4180) begin
      n_fail++; $display("FAIL handler_pc: got %h expected 00004180", handler_pc);
    end
    @(posedge clk);
    wr_ok = w && !e_req;
    nxt_pend = m_pend;
`ifdef CP0_TIMER_EN
    nxt_pend = (m_pend || (m_count == m_compare && m_compare != 32'h0)) && !(wr_ok && a == 5'd11);
    m_count  = (wr_ok && a == 5'd9) ? wd : m_count + 32'd1;
    if (wr_ok && a == 5'd11) m_compare = wd;
`endif
    m_pend = nxt_pend;
    if (e_req) begin
      m_sr    = m_sr | 32'h2;
      m_cause = (bd ? 32'h8000_0000 : 32'h0) | ({26'd0, hw} << 10)
              | (e_int ? 32'h0 : ({27'd0, exc} << 2));
      m_epc   = (bd ? pc - 32'd4 : pc) & 32'hFFFF_FFFC;
    end else begin
      m_cause = (m_cause & ~32'h0000_FC00) | ({26'd0, hw} << 10);
      if (wr_ok && a == 5'd12 && !er) m_sr = wd & 32'h0000_FC03;
      if (er) m_sr = m_sr & ~32'h2;
      if (wr_ok && a == 5'd14) m_epc = wd;
    end
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    drive(0, 5'd12, 0, 0, 0, 0, 0, 0);
    n_tests++;
    if (obs_req !== 1'b0 || obs_epc_out !== 32'h0 || obs_rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_state: req=%0b epc_out=%h sr=%h expected 0/0/0",
               obs_req, obs_epc_out, obs_rdata);
    end
    drive(0, 5'd15, 0, 0, 0, 0, 0, 0);
    n_tests++;
    if (obs_rdata !== 32'h2021_0707) begin
      n_fail++; $display("FAIL reset_prid: got %h expected 20210707", obs_rdata);
    end
  endtask

  task automatic test_interrupt();
    do_reset();
    drive(1, 5'd12, 32'h0000_FC01, 32'h1000, 0, 0, 6'b000100, 0);
    drive(0, 5'd13, 0, 32'h1000, 0, 0, 6'b000100, 0);
    n_tests++;
    if (obs_req !== 1'b1) begin
      n_fail++; $display("FAIL int_req: got %0b expected 1", obs_req);
    end
    drive(0, 5'd13, 0, 32'h1004, 0, 0, 6'b000100, 0);
    n_tests++;
    if (obs_rdata !== 32'h0000_1000 || obs_req !== 1'b0) begin
      n_fail++; $display("FAIL int_cause: got %h req=%0b expected 00001000 req=0", obs_rdata, obs_req);
    end
    drive(0, 5'd14, 0, 32'h1008, 0, 0, 6'b000100, 0);
    n_tests++;
    if (obs_rdata !== 32'h0000_1000) begin
      n_fail++; $display("FAIL int_epc: got %h expected 00001000", obs_rdata);
    end
    // Reset in the middle of the handler must drop EXL.
    do_reset();
    drive(0, 5'd12, 0, 0, 0, 0, 0, 0);
    n_tests++;
    if (obs_rdata !== 32'h0) begin
      n_fail++; $display("FAIL reset_mid_handler: sr=%h expected 00000000", obs_rdata);
    end
  endtask

  task automatic test_exception_eret();
    do_reset();
    drive(0, 5'd0, 0, 32'h3008, 1, 5'd4, 0, 0);
    n_tests++;
    if (obs_req !== 1'b1) begin
      n_fail++; $display("FAIL exc_req: got %0b expected 1", obs_req);
    end
    drive(0, 5'd14, 0, 0, 0, 0, 0, 0);
    n_tests++;
    if (obs_rdata !== 32'h0000_3004) begin
      n_fail++; $display("FAIL exc_epc_bd: got %h expected 00003004", obs_rdata);
    end
    drive(0, 5'd13, 0, 0, 0, 0, 0, 0);
    n_tests++;
    if (obs_rdata !== 32'h8000_0010) begin
      n_fail++; $display("FAIL exc_cause: got %h expected 80000010", obs_rdata);
    end
    drive(0, 5'd12, 0, 0, 0, 5'd10, 6'h3f, 0);
    n_tests++;
    if (obs_rdata !== 32'h2 || obs_req !== 1'b0) begin
      n_fail++; $display("FAIL exl_masks: sr=%h req=%0b expected 00000002 req=0", obs_rdata, obs_req);
    end
    drive(0, 5'd13, 0, 32'h7000, 0, 5'd10, 6'h3f, 1);
    n_tests++;
    if (obs_rdata !== 32'h8000_FC10) begin
      n_fail++; $display("FAIL exl_cause_hold: got %h expected 8000fc10", obs_rdata);
    end
    drive(0, 5'd12, 0, 0, 0, 0, 0, 0);
    n_tests++;
    if (obs_rdata !== 32'h0) begin
      n_fail++; $display("FAIL eret_exl: sr=%h expected 00000000", obs_rdata);
    end
    // Delay-slot victim at address 0 wraps.
    drive(0, 5'd0, 0, 32'h0, 1, 5'd5, 0, 0);
    drive(0, 5'd14, 0, 0, 0, 0, 0, 0);
    n_tests++;
    if (obs_rdata !== 32'hFFFF_FFFC) begin
      n_fail++; $display("FAIL epc_wrap: got %h expected fffffffc", obs_rdata);
    end
  endtask

  task automatic test_epc_forward();
    do_reset();
    drive(1, 5'd14, 32'h3100, 0, 0, 0, 0, 0);
    n_tests++;
    if (obs_epc_out !== 32'h3100) begin
      n_fail++; $display("FAIL epc_fwd: got %h expected 00003100", obs_epc_out);
    end
    drive(0, 5'd14, 0, 0, 0, 0, 0, 0);
    n_tests++;
    if (obs_rdata !== 32'h3100) begin
      n_fail++; $display("FAIL epc_write: got %h expected 00003100", obs_rdata);
    end
    drive(1, 5'd14, 32'h5000, 32'h4002, 0, 5'd12, 0, 0);
    n_tests++;
    if (obs_epc_out !== 32'h3100) begin
      n_fail++; $display("FAIL epc_fwd_on_req: got %h expected 00003100", obs_epc_out);
    end
    drive(0, 5'd14, 0, 0, 0, 0, 0, 0);
    n_tests++;
    if (obs_rdata !== 32'h4000) begin
      n_fail++; $display("FAIL req_drops_mtc0: got %h expected 00004000", obs_rdata);
    end
    // eret with same-cycle mtc0 to EPC: EPC write still lands.
    drive(1, 5'd14, 32'h0000_6003, 0, 0, 0, 0, 1);
    drive(0, 5'd14, 0, 0, 0, 0, 0, 0);
    n_tests++;
    if (obs_rdata !== 32'h0000_6003) begin
      n_fail++; $display("FAIL eret_with_mtc0: got %h expected 00006003", obs_rdata);
    end
  endtask

`ifdef CP0_TIMER_EN
  task automatic test_timer();
    bit seen;
    do_reset();
    drive(1, 5'd12, 32'h0000_8001, 0, 0, 0, 0, 0);
    drive(1, 5'd11, 32'd5, 0, 0, 0, 0, 0);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      drive(0, 5'd9, 0, 32'h100, 0, 0, 0, 0);
      seen = obs_req;
    end
    n_tests++;
    if (!seen) begin
      n_fail++; $display("FAIL timer_req: got no req within 20 cycles expected req");
    end
    drive(0, 5'd13, 0, 0, 0, 0, 0, 0);
    n_tests++;
    if (obs_rdata[15] !== 1'b1) begin
      n_fail++; $display("FAIL timer_ip7: got %0b expected 1", obs_rdata[15]);
    end
    drive(1, 5'd11, 32'd0, 0, 0, 0, 0, 0);
    drive(0, 5'd13, 0, 0, 0, 0, 0, 0);
    n_tests++;
    if (obs_rdata[15] !== 1'b0) begin
      n_fail++; $display("FAIL timer_clear: got %0b expected 0", obs_rdata[15]);
    end
  endtask
`endif

  task automatic test_random();
    logic [4:0] addr_tbl [7];
    addr_tbl = '{5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd3};
    do_reset();
    for (int i = 0; i < 400; i++) begin
      logic [4:0] a;
      logic [5:0] hw;
      logic [4:0] exc;
      if (i % 60 == 59) do_reset();
      a   = ($urandom_range(0, 9) == 0) ? 5'($urandom) : addr_tbl[$urandom_range(0, 6)];
      hw  = ($urandom_range(0, 1) == 0) ? 6'd0 : 6'($urandom);
      exc = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
      drive($urandom_range(0, 9) < 3, a, $urandom, $urandom, 1'($urandom), exc, hw,
            $urandom_range(0, 9) == 0);
    end
  endtask

  initial begin
    test_reset();
    test_interrupt();
    test_exception_eret();
    test_epc_forward();
`ifdef CP0_TIMER_EN
    test_timer();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
